// File: rtl/td_fused_top_ap_hfpu_param.sv
// Half-precision FP unit: LANES parallel lanes sharing one opcode, LATENCY-stage pipe with clock enable.
// Optional macro HFPU_CMP_EN adds the compare opcodes 8'h10 (lt), 8'h11 (eq), 8'h12 (le).

module multiply_fp (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_y
);
  logic        w_sign, w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan;
  logic [21:0] w_p;
  logic        w_norm, w_g, w_st, w_rnd;
  logic [9:0]  w_mant;
  logic [10:0] w_mr;
  logic [6:0]  w_esum;
  logic [4:0]  w_eout;

  // Subnormal operands and results are flushed to signed zero.
  assign w_sign   = i_a[15] ^ i_b[15];
  assign w_zero_a = (i_a[14:10] == 5'h00);
  assign w_zero_b = (i_b[14:10] == 5'h00);
  assign w_inf_a  = (i_a[14:10] == 5'h1F) && (i_a[9:0] == 10'h0);
  assign w_inf_b  = (i_b[14:10] == 5'h1F) && (i_b[9:0] == 10'h0);
  assign w_nan    = ((i_a[14:10] == 5'h1F) && (i_a[9:0] != 10'h0)) ||
                    ((i_b[14:10] == 5'h1F) && (i_b[9:0] != 10'h0)) ||
                    (w_inf_a && w_zero_b) || (w_zero_a && w_inf_b);

  assign w_p    = {11'h0, 1'b1, i_a[9:0]} * {11'h0, 1'b1, i_b[9:0]};
  assign w_norm = w_p[21];
  assign w_mant = w_norm ? w_p[20:11] : w_p[19:10];
  assign w_g    = w_norm ? w_p[10] : w_p[9];
  assign w_st   = w_norm ? (|w_p[9:0]) : (|w_p[8:0]);
  assign w_rnd  = w_g & (w_st | w_mant[0]);
  assign w_mr   = {1'b0, w_mant} + {10'h0, w_rnd};
  assign w_esum = {2'b0, i_a[14:10]} + {2'b0, i_b[14:10]} + {6'h0, w_norm} + {6'h0, w_mr[10]};
  assign w_eout = w_esum[4:0] - 5'd15;

  always_comb begin
    if (w_nan)                                        o_y = 16'h7E00;
    else if (w_inf_a || w_inf_b || w_esum >= 7'd46)   o_y = {w_sign, 5'h1F, 10'h0};
    else if (w_zero_a || w_zero_b || w_esum <= 7'd15) o_y = {w_sign, 15'h0};
    else                                              o_y = {w_sign, w_eout, w_mr[9:0]};
  end
endmodule

module adder_fp (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_y
);
  logic        w_swap, w_nan, w_inf_a, w_inf_b, w_uf, w_rnd;
  logic [15:0] w_x, w_y;
  logic [10:0] w_mx, w_my, w_mr;
  logic [4:0]  w_d;
  logic [24:0] w_bs;
  logic [13:0] w_bsh, w_n;
  logic [14:0] w_s;
  logic [3:0]  w_lz;
  logic [5:0]  w_e, w_ef;

  assign w_inf_a = (i_a[14:10] == 5'h1F) && (i_a[9:0] == 10'h0);
  assign w_inf_b = (i_b[14:10] == 5'h1F) && (i_b[9:0] == 10'h0);
  assign w_nan   = ((i_a[14:10] == 5'h1F) && (i_a[9:0] != 10'h0)) ||
                   ((i_b[14:10] == 5'h1F) && (i_b[9:0] != 10'h0)) ||
                   (w_inf_a && w_inf_b && (i_a[15] != i_b[15]));

  // x is the larger magnitude, so the aligned difference never goes negative.
  assign w_swap = (i_b[14:0] > i_a[14:0]);
  assign w_x    = w_swap ? i_b : i_a;
  assign w_y    = w_swap ? i_a : i_b;
  assign w_mx   = (w_x[14:10] == 5'h00) ? 11'h0 : {1'b1, w_x[9:0]};
  assign w_my   = (w_y[14:10] == 5'h00) ? 11'h0 : {1'b1, w_y[9:0]};
  assign w_d    = w_x[14:10] - w_y[14:10];
  assign w_bs   = {w_my, 14'h0} >> w_d;
  assign w_bsh  = {w_bs[24:12], |w_bs[11:0]};
  assign w_s    = (w_x[15] == w_y[15]) ? ({1'b0, w_mx, 3'b000} + {1'b0, w_bsh})
                                       : ({1'b0, w_mx, 3'b000} - {1'b0, w_bsh});

  always_comb begin
    w_lz = 4'd14;
    for (int unsigned i = 0; i < 14; i++)
      if (w_s[i]) w_lz = 4'(13 - i);
  end

  assign w_n   = w_s[14] ? {w_s[14:2], w_s[1] | w_s[0]} : (w_s[13:0] << w_lz);
  assign w_uf  = !w_s[14] && ({1'b0, w_lz} >= w_x[14:10]);
  assign w_e   = w_s[14] ? ({1'b0, w_x[14:10]} + 6'd1) : ({1'b0, w_x[14:10]} - {2'b0, w_lz});
  assign w_rnd = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
  assign w_mr  = {1'b0, w_n[12:3]} + {10'h0, w_rnd};
  assign w_ef  = w_e + {5'h0, w_mr[10]};

  always_comb begin
    if (w_nan)                o_y = 16'h7E00;
    else if (w_inf_a)         o_y = i_a;
    else if (w_inf_b)         o_y = i_b;
    else if (!w_n[13])        o_y = {w_x[15] & w_y[15], 15'h0};
    else if (w_uf)            o_y = {w_x[15], 15'h0};
    else if (w_ef >= 6'd31)   o_y = {w_x[15], 5'h1F, 10'h0};
    else                      o_y = {w_x[15], w_ef[4:0], w_mr[9:0]};
  end
endmodule

module td_fused_top_ap_hfpu_param #(
  parameter int unsigned LANES   = 1,
  parameter int unsigned LATENCY = 3
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  aclken,
  input  logic                  s_axis_a_tvalid,
  input  logic [16*LANES-1:0]   s_axis_a_tdata,
  input  logic                  s_axis_b_tvalid,
  input  logic [16*LANES-1:0]   s_axis_b_tdata,
  input  logic                  s_axis_operation_tvalid,
  input  logic [7:0]            s_axis_operation_tdata,
  output logic                  m_axis_result_tvalid,
  output logic [16*LANES-1:0]   m_axis_result_tdata,
  output logic                  m_axis_result_tuser,
  output logic [3:0]            occupancy
);
  localparam int unsigned W = 16 * LANES;

  logic             w_accept, w_usr;
  logic [W-1:0]     r_s1_a, r_s1_b;
  logic [7:0]       r_s1_op;
  logic [LATENCY:1] r_vld;
  logic [W-1:0]     r_dat [2:LATENCY];
  logic             r_usr [2:LATENCY];
  logic [3:0]       r_occ;
  logic [W-1:0]     w_mul, w_add, w_res;

  assign w_accept = aclken & s_axis_a_tvalid & s_axis_b_tvalid & s_axis_operation_tvalid;

`ifdef HFPU_CMP_EN
  logic [LANES-1:0] w_lt, w_eq;

  function automatic logic f_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
  endfunction

  // Sign-magnitude ordering; +0 and -0 compare equal, NaN makes everything false.
  function automatic logic f_lt(input logic [15:0] a, input logic [15:0] b);
    if (f_nan(a) || f_nan(b))                  return 1'b0;
    if (a[14:0] == 15'h0 && b[14:0] == 15'h0)  return 1'b0;
    if (a[15] != b[15])                        return a[15];
    return a[15] ? (a[14:0] > b[14:0]) : (a[14:0] < b[14:0]);
  endfunction

  function automatic logic f_eq(input logic [15:0] a, input logic [15:0] b);
    if (f_nan(a) || f_nan(b))                  return 1'b0;
    if (a[14:0] == 15'h0 && b[14:0] == 15'h0)  return 1'b1;
    return a == b;
  endfunction
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [15:0] w_a, w_b, w_bx;
    assign w_a  = r_s1_a[16*g +: 16];
    assign w_b  = r_s1_b[16*g +: 16];
    assign w_bx = (r_s1_op == 8'h02) ? {~w_b[15], w_b[14:0]} : w_b;
    multiply_fp u_mul (.i_a(w_a), .i_b(w_b),  .o_y(w_mul[16*g +: 16]));
    adder_fp    u_add (.i_a(w_a), .i_b(w_bx), .o_y(w_add[16*g +: 16]));
`ifdef HFPU_CMP_EN
    assign w_lt[g] = f_lt(w_a, w_b);
    assign w_eq[g] = f_eq(w_a, w_b);
`endif
  end

  always_comb begin
    w_res = '0;
    w_usr = 1'b0;
    case (r_s1_op)
      8'h00:        w_res = w_mul;
      8'h01, 8'h02: w_res = w_add;
`ifdef HFPU_CMP_EN
      8'h10: for (int unsigned i = 0; i < LANES; i++) w_res[16*i +: 16] = {15'h0, w_lt[i]};
      8'h11: for (int unsigned i = 0; i < LANES; i++) w_res[16*i +: 16] = {15'h0, w_eq[i]};
      8'h12: for (int unsigned i = 0; i < LANES; i++) w_res[16*i +: 16] = {15'h0, w_lt[i] | w_eq[i]};
`endif
      default:      w_usr = 1'b1;
    endcase
  end

  // Bubbles carry zero data/tuser so idle output lanes stay clean.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_s1_a  <= '0;
      r_s1_b  <= '0;
      r_s1_op <= '0;
      r_vld   <= '0;
      r_occ   <= '0;
      for (int unsigned k = 2; k <= LATENCY; k++) begin
        r_dat[k] <= '0;
        r_usr[k] <= 1'b0;
      end
    end else if (aclken) begin
      r_vld <= {r_vld[LATENCY-1:1], w_accept};
      if (w_accept) begin
        r_s1_a  <= s_axis_a_tdata;
        r_s1_b  <= s_axis_b_tdata;
        r_s1_op <= s_axis_operation_tdata;
      end
      r_dat[2] <= r_vld[1] ? w_res : '0;
      r_usr[2] <= r_vld[1] & w_usr;
      for (int unsigned k = 3; k <= LATENCY; k++) begin
        r_dat[k] <= r_dat[k-1];
        r_usr[k] <= r_usr[k-1];
      end
      r_occ <= r_occ + {3'b000, w_accept} - {3'b000, r_vld[LATENCY]};
    end
  end

  assign m_axis_result_tvalid = r_vld[LATENCY];
  assign m_axis_result_tdata  = r_dat[LATENCY];
  assign m_axis_result_tuser  = r_usr[LATENCY];
  assign occupancy            = r_occ;
endmodule

// File: tb/tb_td_fused_top_ap_hfpu_param.sv
// Directed bench for td_fused_top_ap_hfpu_param (LANES=4, LATENCY=3); compare
// expectations follow HFPU_CMP_EN. A result is observed right after edge LAT-1 and consumed at edge LAT.
module tb_td_fused_top_ap_hfpu_param;
  localparam int LANES = 4;
  localparam int LAT   = 3;

  logic        aclk, areset, aclken;
  logic        a_v, b_v, op_v;
  logic [63:0] a_d, b_d;
  logic [7:0]  op_d;
  logic        r_v, r_u;
  logic [63:0] r_d;
  logic [3:0]  occ;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  bt_op [8];
  logic [63:0] bt_a  [8];
  logic [63:0] bt_b  [8];
  logic        ob_v  [8];
  logic [63:0] ob_d  [8];
  logic        ob_u  [8];
  logic [63:0] ex_d  [8];
  logic        ex_u  [8];

`ifdef HFPU_CMP_EN
  localparam logic CMP = 1'b1;
`else
  localparam logic CMP = 1'b0;
`endif

  td_fused_top_ap_hfpu_param #(.LANES(LANES), .LATENCY(LAT)) u_dut (
    .aclk(aclk), .areset(areset), .aclken(aclken),
    .s_axis_a_tvalid(a_v), .s_axis_a_tdata(a_d),
    .s_axis_b_tvalid(b_v), .s_axis_b_tdata(b_d),
    .s_axis_operation_tvalid(op_v), .s_axis_operation_tdata(op_d),
    .m_axis_result_tvalid(r_v), .m_axis_result_tdata(r_d),
    .m_axis_result_tuser(r_u), .occupancy(occ)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] rep(input logic [15:0] x);
    return {x, x, x, x};
  endfunction

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
    a_v = 1'b1; b_v = 1'b1; op_v = 1'b1;
    op_d = op; a_d = a; b_d = b;
  endtask

  task automatic idle;
    a_v = 1'b0; b_v = 1'b0; op_v = 1'b0;
  endtask

  // Issues n beats back to back and captures the output of each in its expected slot.
  task automatic run_beats(input int n);
    for (int c = 0; c < n + LAT; c++) begin
      if (c < n) drive(bt_op[c], bt_a[c], bt_b[c]);
      else       idle();
      tick();
      if (c >= LAT - 1 && c - (LAT - 1) < n) begin
        ob_v[c-(LAT-1)] = r_v;
        ob_d[c-(LAT-1)] = r_d;
        ob_u[c-(LAT-1)] = r_u;
      end
    end
  endtask

  task automatic test_reset;
    areset = 1'b1; aclken = 1'b1; idle(); op_d = 8'h00; a_d = '0; b_d = '0;
    #1;
    n_tests++; if (r_v !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b, expected 0", r_v); end
    n_tests++; if (occ !== 4'd0) begin n_fail++; $display("FAIL reset_occ: got %0d, expected 0", occ); end
    tick(); tick();
    n_tests++; if (r_u !== 1'b0) begin n_fail++; $display("FAIL reset_tuser: got %b, expected 0", r_u); end
    n_tests++; if (r_d !== 64'h0) begin n_fail++; $display("FAIL reset_tdata: got %h, expected 0", r_d); end
    areset = 1'b0;
  endtask

  task automatic test_accept_rule;
    drive(8'h00, rep(16'h4000), rep(16'h4200)); op_v = 1'b0;
    tick();
    n_tests++; if (occ !== 4'd0) begin n_fail++; $display("FAIL accept_no_op: got occ %0d, expected 0", occ); end
    drive(8'h00, rep(16'h4000), rep(16'h4200)); b_v = 1'b0;
    tick();
    n_tests++; if (occ !== 4'd0) begin n_fail++; $display("FAIL accept_no_b: got occ %0d, expected 0", occ); end
    idle();
    repeat (LAT) tick();
    n_tests++; if (r_v !== 1'b0) begin n_fail++; $display("FAIL accept_no_result: got tvalid %b, expected 0", r_v); end
  endtask

  task automatic test_mul;
    drive(8'h00, rep(16'h4000), rep(16'h4200));
    tick(); idle();
    n_tests++; if (occ !== 4'd1 || r_v !== 1'b0) begin n_fail++; $display("FAIL mul_e0: got occ %0d v %b, expected occ 1 v 0", occ, r_v); end
    tick();
    n_tests++; if (occ !== 4'd1 || r_v !== 1'b0) begin n_fail++; $display("FAIL mul_e1: got occ %0d v %b, expected occ 1 v 0", occ, r_v); end
    tick();
    n_tests++; if (r_v !== 1'b1 || r_d !== rep(16'h4600) || r_u !== 1'b0 || occ !== 4'd1) begin
      n_fail++; $display("FAIL mul_e2: got v %b d %h u %b occ %0d, expected v 1 d %h u 0 occ 1", r_v, r_d, r_u, occ, rep(16'h4600)); end
    tick();
    n_tests++; if (r_v !== 1'b0 || occ !== 4'd0) begin n_fail++; $display("FAIL mul_e3: got v %b occ %0d, expected v 0 occ 0", r_v, occ); end
  endtask

  task automatic test_back_to_back;
    drive(8'h01, rep(16'h3C00), rep(16'h3C00)); tick();
    n_tests++; if (occ !== 4'd1) begin n_fail++; $display("FAIL b2b_occ_e0: got %0d, expected 1", occ); end
    drive(8'h02, rep(16'h4200), rep(16'h3C00)); tick(); idle();
    n_tests++; if (occ !== 4'd2 || r_v !== 1'b0) begin n_fail++; $display("FAIL b2b_e1: got occ %0d v %b, expected occ 2 v 0", occ, r_v); end
    tick();
    n_tests++; if (r_v !== 1'b1 || r_d !== rep(16'h4000) || occ !== 4'd2) begin
      n_fail++; $display("FAIL b2b_first: got v %b d %h occ %0d, expected v 1 d %h occ 2", r_v, r_d, occ, rep(16'h4000)); end
    tick();
    n_tests++; if (r_v !== 1'b1 || r_d !== rep(16'h4000) || occ !== 4'd1) begin
      n_fail++; $display("FAIL b2b_second: got v %b d %h occ %0d, expected v 1 d %h occ 1", r_v, r_d, occ, rep(16'h4000)); end
    tick();
    n_tests++; if (r_v !== 1'b0 || occ !== 4'd0) begin n_fail++; $display("FAIL b2b_drain: got v %b occ %0d, expected v 0 occ 0", r_v, occ); end
  endtask

  task automatic test_arith;
    bt_op[0] = 8'h00; bt_a[0] = rep(16'h3C00); bt_b[0] = rep(16'hC000); ex_d[0] = rep(16'hC000); ex_u[0] = 1'b0;
    bt_op[1] = 8'h02; bt_a[1] = rep(16'h3C00); bt_b[1] = rep(16'h4000); ex_d[1] = rep(16'hBC00); ex_u[1] = 1'b0;
    bt_op[2] = 8'h01; bt_a[2] = rep(16'h4000); bt_b[2] = rep(16'hC000); ex_d[2] = rep(16'h0000); ex_u[2] = 1'b0;
    bt_op[3] = 8'h01; bt_a[3] = rep(16'h7C00); bt_b[3] = rep(16'h3C00); ex_d[3] = rep(16'h7C00); ex_u[3] = 1'b0;
    bt_op[4] = 8'h02; bt_a[4] = rep(16'h7C00); bt_b[4] = rep(16'h7C00); ex_d[4] = rep(16'h7E00); ex_u[4] = 1'b0;
    bt_op[5] = 8'h01; bt_a[5] = rep(16'h3C00); bt_b[5] = rep(16'h1400); ex_d[5] = rep(16'h3C01); ex_u[5] = 1'b0;
    bt_op[6] = 8'h01; bt_a[6] = rep(16'h3C00); bt_b[6] = rep(16'h1000); ex_d[6] = rep(16'h3C00); ex_u[6] = 1'b0;
    bt_op[7] = 8'h00; bt_a[7] = rep(16'h3C01); bt_b[7] = rep(16'h3C01); ex_d[7] = rep(16'h3C02); ex_u[7] = 1'b0;
    run_beats(8);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (ob_v[i] !== 1'b1 || ob_d[i] !== ex_d[i] || ob_u[i] !== ex_u[i]) begin
        n_fail++; $display("FAIL arith[%0d]: got v %b d %h u %b, expected v 1 d %h u %b", i, ob_v[i], ob_d[i], ob_u[i], ex_d[i], ex_u[i]);
      end
    end
  endtask

  task automatic test_cmp;
    logic [6:0] truth;
    truth = 7'b0110011;
    bt_op[0] = 8'h10; bt_a[0] = rep(16'h3C00); bt_b[0] = rep(16'h4000);
    bt_op[1] = 8'h11; bt_a[1] = rep(16'h8000); bt_b[1] = rep(16'h0000);
    bt_op[2] = 8'h11; bt_a[2] = rep(16'h7E00); bt_b[2] = rep(16'h7E00);
    bt_op[3] = 8'h12; bt_a[3] = rep(16'h4000); bt_b[3] = rep(16'h3C00);
    bt_op[4] = 8'h10; bt_a[4] = rep(16'hC000); bt_b[4] = rep(16'hBC00);
    bt_op[5] = 8'h12; bt_a[5] = rep(16'h8000); bt_b[5] = rep(16'h0000);
    bt_op[6] = 8'h10; bt_a[6] = rep(16'h7E00); bt_b[6] = rep(16'h3C00);
    for (int i = 0; i < 7; i++) begin
      ex_d[i] = CMP ? rep({15'h0, truth[i]}) : 64'h0;
      ex_u[i] = ~CMP;
    end
    run_beats(7);
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (ob_v[i] !== 1'b1 || ob_d[i] !== ex_d[i] || ob_u[i] !== ex_u[i]) begin
        n_fail++; $display("FAIL cmp[%0d]: got v %b d %h u %b, expected v 1 d %h u %b", i, ob_v[i], ob_d[i], ob_u[i], ex_d[i], ex_u[i]);
      end
    end
  endtask

  task automatic test_lanes;
    bt_op[0] = 8'h00;
    bt_a[0] = {16'h4000, 16'h3C00, 16'hC000, 16'h0000};
    bt_b[0] = {16'h4200, 16'h3C00, 16'h4000, 16'h7C00};
    ex_d[0] = {16'h4600, 16'h3C00, 16'hC400, 16'h7E00}; ex_u[0] = 1'b0;
    bt_op[1] = 8'h01;
    bt_a[1] = {16'h4000, 16'h3C00, 16'hC000, 16'h0000};
    bt_b[1] = {16'h4200, 16'h3C00, 16'h4000, 16'h8000};
    ex_d[1] = {16'h4500, 16'h4000, 16'h0000, 16'h0000}; ex_u[1] = 1'b0;
    run_beats(2);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (ob_v[i] !== 1'b1 || ob_d[i] !== ex_d[i] || ob_u[i] !== ex_u[i]) begin
        n_fail++; $display("FAIL lanes[%0d]: got v %b d %h u %b, expected v 1 d %h u %b", i, ob_v[i], ob_d[i], ob_u[i], ex_d[i], ex_u[i]);
      end
    end
  endtask

  task automatic test_stall;
    drive(8'h00, rep(16'h4000), rep(16'h4200));
    tick();
    aclken = 1'b0;
    drive(8'h01, rep(16'h3C00), rep(16'h3C00));
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (occ !== 4'd1 || r_v !== 1'b0) begin n_fail++; $display("FAIL stall_hold[%0d]: got occ %0d v %b, expected occ 1 v 0", i, occ, r_v); end
    end
    idle(); aclken = 1'b1;
    tick();
    n_tests++; if (r_v !== 1'b0) begin n_fail++; $display("FAIL stall_early: got v %b, expected 0", r_v); end
    tick();
    n_tests++; if (r_v !== 1'b1 || r_d !== rep(16'h4600)) begin
      n_fail++; $display("FAIL stall_result: got v %b d %h, expected v 1 d %h", r_v, r_d, rep(16'h4600)); end
    aclken = 1'b0;
    tick(); tick();
    n_tests++; if (r_v !== 1'b1 || r_d !== rep(16'h4600) || occ !== 4'd1) begin
      n_fail++; $display("FAIL stall_out_hold: got v %b d %h occ %0d, expected v 1 d %h occ 1", r_v, r_d, occ, rep(16'h4600)); end
    aclken = 1'b1;
    tick();
    n_tests++; if (r_v !== 1'b0 || occ !== 4'd0) begin n_fail++; $display("FAIL stall_drain: got v %b occ %0d, expected v 0 occ 0", r_v, occ); end
  endtask

  task automatic test_reset_flight;
    logic seen;
    for (int i = 0; i < 3; i++) begin
      drive(8'h00, rep(16'h4000), rep(16'h4200));
      tick();
    end
    idle();
    n_tests++; if (occ !== 4'd3) begin n_fail++; $display("FAIL flight_occ: got %0d, expected 3", occ); end
    #1 areset = 1'b1;
    #1;
    n_tests++; if (occ !== 4'd0 || r_v !== 1'b0 || r_d !== 64'h0) begin
      n_fail++; $display("FAIL async_reset: got occ %0d v %b d %h, expected occ 0 v 0 d 0", occ, r_v, r_d); end
    #1 areset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (r_v) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flight_discard: got tvalid seen %b, expected 0", seen); end
    bt_op[0] = 8'h55; bt_a[0] = rep(16'h4000); bt_b[0] = rep(16'h4200); ex_d[0] = 64'h0;          ex_u[0] = 1'b1;
    bt_op[1] = 8'h00; bt_a[1] = rep(16'h3C00); bt_b[1] = rep(16'h3C00); ex_d[1] = rep(16'h3C00); ex_u[1] = 1'b0;
    run_beats(2);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (ob_v[i] !== 1'b1 || ob_d[i] !== ex_d[i] || ob_u[i] !== ex_u[i]) begin
        n_fail++; $display("FAIL post_reset[%0d]: got v %b d %h u %b, expected v 1 d %h u %b", i, ob_v[i], ob_d[i], ob_u[i], ex_d[i], ex_u[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_accept_rule();
    test_mul();
    test_back_to_back();
    test_arith();
    test_cmp();
    test_lanes();
    test_stall();
    test_reset_flight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/td_fused_top_ap_hfpu_param.md
TD_FUSED_TOP_AP_HFPU_PARAM -- requirements
Module: td_fused_top_ap_hfpu_param

Interface
REQ-001 SHALL have parameter LANES, default 1, number of parallel 16-bit half-precision lanes sharing one opcode (legal 1..8).
REQ-002 SHALL have parameter LATENCY, default 3, enabled-cycles from beat acceptance to result valid (legal 2..8).
REQ-003 SHALL have port aclk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port areset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port aclken  in  1  global clock enable; low freezes all pipeline state.
REQ-006 SHALL have ports s_axis_a_tvalid / s_axis_b_tvalid  in  1 each  operand valids.
REQ-007 SHALL have ports s_axis_a_tdata / s_axis_b_tdata  in  16*LANES each  operands; lane i occupies bits [16i+15:16i].
REQ-008 SHALL have ports s_axis_operation_tvalid  in  1 and s_axis_operation_tdata  in  8  opcode valid and opcode.
REQ-009 SHALL have port m_axis_result_tvalid  out  1  result valid.
REQ-010 SHALL have port m_axis_result_tdata  out  16*LANES  per-lane result.
REQ-011 SHALL have port m_axis_result_tuser  out  1  illegal-opcode flag travelling with the result.
REQ-012 SHALL have port occupancy  out  4  count of valid beats currently in flight.

Function
REQ-013 Opcodes SHALL be: 8'h00 mul, 8'h01 add, 8'h02 sub (a-b via sign flip of b), 8'h10 cmp_lt, 8'h11 cmp_eq, 8'h12 cmp_le; all others illegal.
REQ-014 A beat SHALL be accepted on an edge where aclken, s_axis_a_tvalid, s_axis_b_tvalid and s_axis_operation_tvalid are all 1; otherwise a bubble enters.
REQ-015 Stage 1 SHALL register operands and opcode; mul/add/sub SHALL use the multiply_fp / adder_fp primitives per lane on stage-1 registers; stages 2..LATENCY SHALL be a register shift chain.
REQ-016 m_axis_result_tvalid SHALL assert exactly LATENCY aclken-high edges after acceptance, for one enabled cycle per accepted beat; back-to-back beats SHALL give back-to-back results.
REQ-017 With aclken low, every stage, tvalid, tuser, tdata and occupancy SHALL hold their values.
REQ-018 Compare results SHALL be 16'h0001 (true) or 16'h0000 (false) per lane, computed by exact sign-magnitude comparison, not subtraction.
REQ-019 Compares SHALL treat +0 and -0 as equal; any NaN operand (exponent 5'h1F, mantissa non-zero) SHALL make all compares false.
REQ-020 Illegal opcode SHALL give all-zero tdata with m_axis_result_tuser=1; legal opcodes give tuser=0.
REQ-021 occupancy SHALL equal number of set valid bits in the pipe: on an enabled edge +1 for accept, -1 for retire of last stage, unchanged when both; range 0..LATENCY.
REQ-022 Inputs presented with aclken low SHALL NOT be accepted.

Reset
REQ-023 areset high SHALL immediately clear all valid bits, occupancy to 0, tuser to 0, tdata and stage registers to 0, independent of aclk and aclken.
REQ-024 Beats in flight at reset SHALL be discarded and never produce tvalid; first acceptance after release follows REQ-016.

Configuration
REQ-025 Macro HFPU_CMP_EN SHALL compile in comparator logic; defined: opcodes 8'h10-8'h12 per REQ-018/019.
REQ-026 With HFPU_CMP_EN undefined, no comparator logic SHALL exist and 8'h10-8'h12 SHALL be illegal per REQ-020; mul/add/sub unaffected.

Verification
REQ-027 LATENCY=3, mul a=16'h4000 b=16'h4200 accepted at edge 0 -> tvalid at edge 3, tdata 16'h4600, tuser 0, occupancy 1 during flight.
REQ-028 add 16'h3C00+16'h3C00 then sub 16'h4200-16'h3C00 back-to-back -> consecutive results 16'h4000, 16'h4000; occupancy peaks 2.
REQ-029 CMP_EN defined: cmp_lt 3C00,4000 -> 0001; cmp_eq 8000,0000 -> 0001; cmp_eq 7E00,7E00 -> 0000; cmp_le 4000,3C00 -> 0000.
REQ-030 aclken low 4 cycles after acceptance -> tvalid delayed by exactly 4 cycles, data unchanged; inputs during stall ignored.
REQ-031 areset pulsed with 3 beats in flight -> no tvalid afterwards, occupancy 0 asynchronously; opcode 8'h55 -> tdata 0, tuser 1.
REQ-032 LANES=4, mul lanes {4000*4200, 3C00*3C00, C000*4000, 0000*7C00} -> {4600, 3C00, C400, 7E00-class NaN per primitive}.
